// File: rtl/chameleon_spi_flash_writer_pkg.sv
// Shared chameleon flash constants: SPI NOR command opcodes, the position of
// the write-in-progress bit in the status register, the writer FSM state
// type and a helper that tests a status byte for write-in-progress.
package chameleon_spi_flash_writer_pkg;

   localparam logic [7:0] OP_WREN         = 8'h06;
   localparam logic [7:0] OP_SECTOR_ERASE = 8'h20;
   localparam logic [7:0] OP_PAGE_PROG    = 8'h02;
   localparam logic [7:0] OP_READ_STATUS  = 8'h05;

   localparam int         WIP_BIT  = 0;
   localparam logic [7:0] WIP_MASK = 8'(1 << WIP_BIT);

   // The deselect counter runs 0..DESELECT_LAST, so chip select stays high
   // for DESELECT_LAST+1 cycles between two commands.
   localparam logic [2:0] DESELECT_LAST = 3'd3;

   typedef enum logic [2:0] {
      IDLE,
      WREN,
      ERASE,
      PROG_HDR,
      PROG_DATA,
      POLL,
      DESELECT,
      DONE
   } writerState_e;

   function automatic logic statusBusy(input logic [7:0] status);
      return |(status & WIP_MASK);
   endfunction

endpackage

// File: rtl/chameleon_spi_flash_writer_cmd_seq.sv
// flash_cmd_seq: pushes one command byte, optionally followed by a 24-bit
// address (MSB first), onto the toggle-handshake SPI byte engine.
// A command without an address doubles as a plain single-byte transfer.
// Ports:
//   clk, reset_n       clock and asynchronous active-low reset
//   cmdStart           launch a command (only while idle or on seqDone)
//   cmdByte            first byte to send
//   cmdAddr            address bytes sent after cmdByte when cmdWithAddr=1
//   cmdWithAddr        append the 3 address bytes
//   spiReq/spiAck      toggle request / acknowledge to the byte engine
//   spiD               byte currently presented to the engine
//   seqActive          a command is being shifted out
//   seqDone            one-cycle flag: last byte of the command acknowledged
module flash_cmd_seq (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmdStart,
   input  logic [7:0]  cmdByte,
   input  logic [23:0] cmdAddr,
   input  logic        cmdWithAddr,
   input  logic        spiAck,
   output logic        spiReq,
   output logic [7:0]  spiD,
   output logic        seqActive,
   output logic        seqDone
);

   logic        reqQ, reqD;
   logic [7:0]  dataQ, dataD;
   logic        activeQ, activeD;
   logic [1:0]  remQ, remD;
   logic [23:0] addrQ, addrD;
   logic        byteDone;

   assign byteDone = activeQ && (spiAck == reqQ);

   // Byte sequencing: when the engine acknowledges a byte either the next
   // address byte is issued (remQ counts address bytes still to go) or the
   // command is finished. A new start may arrive in the same cycle as
   // seqDone, so it is applied last and overrides the idle transition.
   always_comb begin
      reqD    = reqQ;
      dataD   = dataQ;
      activeD = activeQ;
      remD    = remQ;
      addrD   = addrQ;
      seqDone = byteDone && (remQ == 2'd0);
      if (byteDone) begin
         if (remQ == 2'd0) begin
            activeD = 1'b0;
         end else begin
            reqD = ~reqQ;
            remD = remQ - 2'd1;
            case (remQ)
               2'd3:    dataD = addrQ[23:16];
               2'd2:    dataD = addrQ[15:8];
               default: dataD = addrQ[7:0];
            endcase
         end
      end
      if (cmdStart) begin
         reqD    = ~reqQ;
         dataD   = cmdByte;
         activeD = 1'b1;
         remD    = cmdWithAddr ? 2'd3 : 2'd0;
         addrD   = cmdAddr;
      end
   end

   // Handshake state registers; the engine shares our reset so its ack
   // starts at 0 matching reqQ.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         reqQ    <= 1'b0;
         dataQ   <= 8'h00;
         activeQ <= 1'b0;
         remQ    <= 2'd0;
         addrQ   <= 24'h0;
      end else begin
         reqQ    <= reqD;
         dataQ   <= dataD;
         activeQ <= activeD;
         remQ    <= remD;
         addrQ   <= addrD;
      end
   end

   assign spiReq    = reqQ;
   assign spiD      = dataQ;
   assign seqActive = activeQ;

endmodule

// File: rtl/chameleon_spi_flash_writer.sv
// chameleon_spi_flash_writer: copies a block of bytes from a source memory
// into SPI NOR flash, optionally erasing 4 KiB sectors first. Pages are
// split so no program crosses a 256-byte boundary; after every erase or
// program the status register is polled until write-in-progress clears.
// Ports:
//   clk, reset_n               clock and asynchronous active-low reset
//   start, erase, start_addr,
//   flash_offset, amount       job request, sampled on an accepted start
//   busy, error                job running / last job timed out polling
//   cs_n                       flash chip select
//   spi_req/spi_ack/spi_d/spi_q  toggle handshake to the SPI byte engine
//   mem_req/mem_ack/mem_a/mem_d  toggle handshake to the source memory
module chameleon_spi_flash_writer
   import chameleon_spi_flash_writer_pkg::*;
#(
   parameter int a_bits     = 14,
   parameter int poll_limit = 1048575
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              erase,
   input  logic [a_bits-1:0] start_addr,
   input  logic [23:0]       flash_offset,
   input  logic [15:0]       amount,
   output logic              busy,
   output logic              error,
   output logic              cs_n,
   output logic              spi_req,
   input  logic              spi_ack,
   output logic [7:0]        spi_d,
   input  logic [7:0]        spi_q,
   output logic              mem_req,
   input  logic              mem_ack,
   output logic [a_bits-1:0] mem_a,
   input  logic [7:0]        mem_d
);

   localparam int            PW        = $clog2(poll_limit + 1);
   localparam logic [PW-1:0] POLL_LAST = PW'(poll_limit - 1);

   writerState_e      stateQ, stateD, afterQ, afterD;
   logic [2:0]        gapQ, gapD;
   logic              issuedQ, issuedD, readingQ, readingD;
   logic [a_bits-1:0] srcQ, srcD;
   logic [23:0]       flashQ, flashD, flashNext;
   logic [15:0]       remainQ, remainD, remainNext;
   logic              eraseQ, eraseD, pendEraseQ, pendEraseD;
   logic              memReqQ, memReqD;
   logic [PW-1:0]     pollCntQ, pollCntD;
   logic              busyQ, busyD, errorQ, errorD, csQ, csD;
   logic              seqStart, seqWithAddr, seqActive, seqDone;
   logic [7:0]        seqByte;
   logic              startOk, memReady, pageEnd, wipSet;

   assign startOk    = (stateQ == IDLE) && start && (amount != 16'd0);
   assign flashNext  = flashQ + 24'd1;
   assign remainNext = remainQ - 16'd1;
   assign pageEnd    = (flashNext[7:0] == 8'h00) || (remainNext == 16'd0);
   assign memReady   = issuedQ && (mem_ack == memReqQ);
   assign wipSet     = statusBusy(spi_q);

   // State register plus all job datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stateQ     <= IDLE;
         afterQ     <= IDLE;
         gapQ       <= 3'd0;
         issuedQ    <= 1'b0;
         readingQ   <= 1'b0;
         srcQ       <= '0;
         flashQ     <= 24'h0;
         remainQ    <= 16'd0;
         eraseQ     <= 1'b0;
         pendEraseQ <= 1'b0;
         memReqQ    <= 1'b0;
         pollCntQ   <= '0;
         busyQ      <= 1'b0;
         errorQ     <= 1'b0;
         csQ        <= 1'b1;
      end else begin
         stateQ     <= stateD;
         afterQ     <= afterD;
         gapQ       <= gapD;
         issuedQ    <= issuedD;
         readingQ   <= readingD;
         srcQ       <= srcD;
         flashQ     <= flashD;
         remainQ    <= remainD;
         eraseQ     <= eraseD;
         pendEraseQ <= pendEraseD;
         memReqQ    <= memReqD;
         pollCntQ   <= pollCntD;
         busyQ      <= busyD;
         errorQ     <= errorD;
         csQ        <= csD;
      end
   end

   // Next-state logic. Every finished command goes through DESELECT, with
   // afterD remembering where to resume, so chip select always sees a gap.
   // The page header flows straight into the data bytes in the same frame.
   always_comb begin
      stateD = stateQ;
      afterD = afterQ;
      case (stateQ)
         IDLE:      if (startOk) stateD = WREN;
         WREN: begin
            if (issuedQ && seqDone) begin
               stateD = DESELECT;
               afterD = pendEraseQ ? ERASE : PROG_HDR;
            end
         end
         ERASE: begin
            if (issuedQ && seqDone) begin
               stateD = DESELECT;
               afterD = POLL;
            end
         end
         PROG_HDR:  if (issuedQ && seqDone) stateD = PROG_DATA;
         PROG_DATA: begin
            if (seqDone && pageEnd) begin
               stateD = DESELECT;
               afterD = POLL;
            end
         end
         POLL: begin
            if (readingQ && seqDone) begin
               if (!wipSet) begin
                  stateD = DESELECT;
                  afterD = (remainQ == 16'd0) ? DONE : WREN;
               end else if (pollCntQ == POLL_LAST) begin
                  stateD = DESELECT;
                  afterD = DONE;
               end
            end
         end
         DESELECT:  if (gapQ == DESELECT_LAST) stateD = afterQ;
         DONE:      stateD = IDLE;
         default:   stateD = IDLE;
      endcase
   end

   // Outputs and datapath. issuedQ marks that the current state's command
   // (or, in PROG_DATA, the memory fetch) has been launched; readingQ marks
   // that the poll opcode is out and status reads are in flight. A sector
   // erase becomes pending at the job start and whenever the flash address
   // steps onto a 4 KiB boundary, and is consumed when ERASE launches.
   always_comb begin
      gapD        = gapQ;
      issuedD     = issuedQ;
      readingD    = readingQ;
      srcD        = srcQ;
      flashD      = flashQ;
      remainD     = remainQ;
      eraseD      = eraseQ;
      pendEraseD  = pendEraseQ;
      memReqD     = memReqQ;
      pollCntD    = pollCntQ;
      busyD       = busyQ;
      errorD      = errorQ;
      seqStart    = 1'b0;
      seqByte     = 8'h00;
      seqWithAddr = 1'b0;
      case (stateQ)
         IDLE: begin
            if (startOk) begin
               busyD      = 1'b1;
               errorD     = 1'b0;
               srcD       = start_addr;
               flashD     = flash_offset;
               remainD    = amount;
               eraseD     = erase;
               pendEraseD = erase;
            end
         end
         WREN: begin
            if (!issuedQ) begin
               seqStart = 1'b1;
               seqByte  = OP_WREN;
               issuedD  = 1'b1;
            end
         end
         ERASE: begin
            if (!issuedQ) begin
               seqStart    = 1'b1;
               seqByte     = OP_SECTOR_ERASE;
               seqWithAddr = 1'b1;
               issuedD     = 1'b1;
               pendEraseD  = 1'b0;
            end
         end
         PROG_HDR: begin
            if (!issuedQ) begin
               seqStart    = 1'b1;
               seqByte     = OP_PAGE_PROG;
               seqWithAddr = 1'b1;
               issuedD     = 1'b1;
            end
         end
         PROG_DATA: begin
            if (!issuedQ && !seqActive) begin
               memReqD = ~memReqQ;
               issuedD = 1'b1;
            end else if (memReady) begin
               seqStart = 1'b1;
               seqByte  = mem_d;
               issuedD  = 1'b0;
            end
            if (seqDone) begin
               srcD    = srcQ + 1'b1;
               flashD  = flashNext;
               remainD = remainNext;
               if (flashNext[11:0] == 12'h000) pendEraseD = eraseQ;
            end
         end
         POLL: begin
            if (!issuedQ) begin
               seqStart = 1'b1;
               seqByte  = OP_READ_STATUS;
               issuedD  = 1'b1;
               pollCntD = '0;
            end else if (seqDone) begin
               if (!readingQ) begin
                  seqStart = 1'b1;
                  readingD = 1'b1;
               end else begin
                  pollCntD = pollCntQ + 1'b1;
                  if (wipSet) begin
                     if (pollCntQ == POLL_LAST) errorD = 1'b1;
                     else seqStart = 1'b1;
                  end
               end
            end
         end
         DESELECT:  gapD  = gapQ + 3'd1;
         DONE:      busyD = 1'b0;
         default:   ;
      endcase
      if (stateD != stateQ) begin
         issuedD  = 1'b0;
         readingD = 1'b0;
         gapD     = 3'd0;
      end
      csD = !(stateD inside {WREN, ERASE, PROG_HDR, PROG_DATA, POLL});
   end

   flash_cmd_seq cmdSeq (
      .clk         (clk),
      .reset_n     (reset_n),
      .cmdStart    (seqStart),
      .cmdByte     (seqByte),
      .cmdAddr     (flashQ),
      .cmdWithAddr (seqWithAddr),
      .spiAck      (spi_ack),
      .spiReq      (spi_req),
      .spiD        (spi_d),
      .seqActive   (seqActive),
      .seqDone     (seqDone)
   );

   assign busy    = busyQ;
   assign error   = errorQ;
   assign cs_n    = csQ;
   assign mem_req = memReqQ;
   assign mem_a   = srcQ;

endmodule
